// File: rtl/mem_subword_ctrl.sv
// mem_subword_ctrl: memory-stage access controller.
// Turns byte/halfword stores into a two-cycle read-modify-write against a
// word-only BRAM, aligns and sign-extends sub-word loads, and counts RMW writes.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap and suppress misaligned
// halfword/word accesses instead of force-aligning them).
module mem_subword_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] EX_MEM_Address,
    input  logic [31:0]       EX_MEM_WriteData,
    input  logic              EX_MEM_MemWrite,
    input  logic              EX_MEM_MemRead,
    input  logic              EX_MEM_HalfControl,
    input  logic              EX_MEM_ByteControl,
    input  logic [31:0]       Mem_ReadData,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [31:0]       Mem_WriteData,
    output logic              Mem_MemWrite,
    output logic [31:0]       Load_Data,
    output logic              Stall,
    output logic              Misalign_Err,
    output logic [CNT_W-1:0]  Rmw_Count
);

    typedef enum logic {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_word;
    logic [CNT_W-1:0]  cnt_q;
    logic              rmw_start_c;

    logic [ADDR_W-1:0] word_addr_c;
    logic [1:0]        lane_c;
    logic              is_half_c;
    logic              is_byte_c;
    logic              misalign_c;
    logic [15:0]       half_c;
    logic [7:0]        byte_c;
    logic [31:0]       load_c;

    // Replace the addressed lane(s) of the old word with the store data.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [15:0] data,
                                               input logic        half,
                                               input logic [1:0]  lane);
        logic [31:0] m;
        m = old_word;
        if (half) begin
            if (lane[1]) m[31:16] = data;
            else         m[15:0]  = data;
        end else begin
            m[{lane, 3'b000} +: 8] = data[7:0];
        end
        return m;
    endfunction

    // Access decode: halfword wins over byte, neither means word.
    always_comb begin
        word_addr_c = {EX_MEM_Address[ADDR_W-1:2], 2'b00};
        lane_c      = EX_MEM_Address[1:0];
        is_half_c   = EX_MEM_HalfControl;
        is_byte_c   = EX_MEM_ByteControl & ~EX_MEM_HalfControl;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_c  = (EX_MEM_MemRead | EX_MEM_MemWrite) & (state == IDLE) &
                      (is_half_c ? lane_c[0] : (~is_byte_c & (lane_c != 2'b00)));
`else
        misalign_c  = 1'b0;
`endif
    end

    // Load alignment and sign extension from the raw memory word.
    always_comb begin
        half_c = lane_c[1] ? Mem_ReadData[31:16] : Mem_ReadData[15:0];
        byte_c = Mem_ReadData[{lane_c, 3'b000} +: 8];
        if (is_half_c)      load_c = {{16{half_c[15]}}, half_c};
        else if (is_byte_c) load_c = {{24{byte_c[7]}}, byte_c};
        else                load_c = Mem_ReadData;
        Load_Data = '0;
        if ((state == IDLE) && EX_MEM_MemRead && !EX_MEM_MemWrite && !misalign_c)
            Load_Data = load_c;
    end

    // Next-state and memory-side outputs.
    always_comb begin
        state_nxt     = state;
        Mem_Address   = word_addr_c;
        Mem_WriteData = EX_MEM_WriteData;
        Mem_MemWrite  = 1'b0;
        Stall         = 1'b0;
        rmw_start_c   = 1'b0;
        case (state)
            IDLE: begin
                if (EX_MEM_MemWrite && !misalign_c) begin
                    if (is_half_c || is_byte_c) begin
                        Stall       = 1'b1;
                        rmw_start_c = 1'b1;
                        state_nxt   = RMW_WRITE;
                    end else begin
                        Mem_MemWrite = 1'b1;
                    end
                end
            end
            RMW_WRITE: begin
                Mem_Address   = lat_addr;
                Mem_WriteData = lat_word;
                Mem_MemWrite  = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset must kill any write in flight, including mid-RMW.
        if (!Rst_n) begin
            Mem_MemWrite = 1'b0;
            Stall        = 1'b0;
            rmw_start_c  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture target address and merged word during the read cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lat_addr <= '0;
            lat_word <= '0;
        end else if (rmw_start_c) begin
            lat_addr <= word_addr_c;
            lat_word <= merge_word(Mem_ReadData, EX_MEM_WriteData[15:0], is_half_c, lane_c);
        end
    end

    // Saturating count of completed RMW writes.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            cnt_q <= '0;
        else if ((state == RMW_WRITE) && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign Rmw_Count = cnt_q;

`ifdef MEM_MISALIGN_TRAP_EN
    logic err_q;

    // One-cycle misalignment pulse, registered after the offending access.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) err_q <= 1'b0;
        else        err_q <= misalign_c;
    end

    assign Misalign_Err = err_q;
`else
    assign Misalign_Err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_subword_ctrl.sv
// Scoreboard bench for mem_subword_ctrl with a falling-edge word memory model.
module tb_mem_subword_ctrl;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic        stall;
        logic        mw;
        logic [31:0] ld;
        logic [15:0] cnt;
        logic        misal;
    } cyc_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] EX_MEM_Address;
    logic [31:0] EX_MEM_WriteData;
    logic        EX_MEM_MemWrite;
    logic        EX_MEM_MemRead;
    logic        EX_MEM_HalfControl;
    logic        EX_MEM_ByteControl;
    logic [31:0] Mem_ReadData;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_WriteData;
    logic        Mem_MemWrite;
    logic [31:0] Load_Data;
    logic        Stall;
    logic        Misalign_Err;
    logic [15:0] Rmw_Count;

    mem_subword_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
        .Clk                (Clk),
        .Rst_n              (Rst_n),
        .EX_MEM_Address     (EX_MEM_Address),
        .EX_MEM_WriteData   (EX_MEM_WriteData),
        .EX_MEM_MemWrite    (EX_MEM_MemWrite),
        .EX_MEM_MemRead     (EX_MEM_MemRead),
        .EX_MEM_HalfControl (EX_MEM_HalfControl),
        .EX_MEM_ByteControl (EX_MEM_ByteControl),
        .Mem_ReadData       (Mem_ReadData),
        .Mem_Address        (Mem_Address),
        .Mem_WriteData      (Mem_WriteData),
        .Mem_MemWrite       (Mem_MemWrite),
        .Load_Data          (Load_Data),
        .Stall              (Stall),
        .Misalign_Err       (Misalign_Err),
        .Rmw_Count          (Rmw_Count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Word memory: read-first, samples on the falling edge.
    logic [31:0] mem [0:63];
    always @(negedge Clk) begin
        if (Mem_MemWrite) mem[Mem_Address[7:2]] <= Mem_WriteData;
        Mem_ReadData <= mem[Mem_Address[7:2]];
    end

    cyc_t cq[$];
    wr_t  wq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rec_idx  = 0;
    bit   done     = 1'b0;
    logic [15:0] exp_cnt    = 16'd0;
    logic        misal_pend = 1'b0;

    // Monitor: checks every memory write, then one per-cycle record.
    always @(negedge Clk) begin
        cyc_t r;
        wr_t  w;
        if (Mem_MemWrite) begin
            n_checks++;
            if (wq.size() == 0) begin
                n_fail++;
                $display("FAIL mem_write unexpected: got addr=%h data=%h, want no write", Mem_Address, Mem_WriteData);
            end else begin
                w = wq.pop_front();
                if (Mem_Address !== w.addr || Mem_WriteData !== w.data) begin
                    n_fail++;
                    $display("FAIL mem_write: got addr=%h data=%h, want addr=%h data=%h", Mem_Address, Mem_WriteData, w.addr, w.data);
                end
            end
        end
        #2;
        if (cq.size() != 0) begin
            r = cq.pop_front();
            n_checks += 5;
            if (Stall !== r.stall) begin
                n_fail++; $display("FAIL stall rec %0d: got %b want %b", rec_idx, Stall, r.stall);
            end
            if (Mem_MemWrite !== r.mw) begin
                n_fail++; $display("FAIL mem_memwrite rec %0d: got %b want %b", rec_idx, Mem_MemWrite, r.mw);
            end
            if (Load_Data !== r.ld) begin
                n_fail++; $display("FAIL load_data rec %0d: got %h want %h", rec_idx, Load_Data, r.ld);
            end
            if (Rmw_Count !== r.cnt) begin
                n_fail++; $display("FAIL rmw_count rec %0d: got %0d want %0d", rec_idx, Rmw_Count, r.cnt);
            end
            if (Misalign_Err !== r.misal) begin
                n_fail++; $display("FAIL misalign_err rec %0d: got %b want %b", rec_idx, Misalign_Err, r.misal);
            end
            rec_idx++;
        end
        if (done && cq.size() == 0) begin
            n_checks++;
            if (wq.size() != 0) begin
                n_fail++;
                $display("FAIL mem_write missing: got %0d writes outstanding, want 0", wq.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic push_rec(input logic e_stall, input logic e_mw, input logic [31:0] e_ld, input logic e_trap);
        cyc_t r;
        r.stall = e_stall;
        r.mw    = e_mw;
        r.ld    = e_ld;
        r.cnt   = exp_cnt;
        r.misal = misal_pend;
        cq.push_back(r);
        misal_pend = e_trap;
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] d,
                        input logic mw, input logic mr, input logic hw, input logic bt,
                        input logic e_stall, input logic e_mw, input logic [31:0] e_ld, input logic e_trap);
        @(posedge Clk);
        #1;
        EX_MEM_Address     = a;
        EX_MEM_WriteData   = d;
        EX_MEM_MemWrite    = mw;
        EX_MEM_MemRead     = mr;
        EX_MEM_HalfControl = hw;
        EX_MEM_ByteControl = bt;
        push_rec(e_stall, e_mw, e_ld, e_trap);
    endtask

    task automatic idle();
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic load(input logic [31:0] a, input logic hw, input logic bt,
                        input logic [31:0] e_ld, input logic e_trap);
        step(a, 32'h0, 1'b0, 1'b1, hw, bt, 1'b0, 1'b0, e_ld, e_trap);
    endtask

    task automatic store_word(input logic [31:0] a, input logic [31:0] d, input logic mr);
        wr_t w;
        step(a, d, 1'b1, mr, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        w.addr = a & 32'hFFFF_FFFC;
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic store_sub(input logic [31:0] a, input logic [31:0] d, input logic hw, input logic bt,
                             input logic [31:0] merged, input logic e_trap);
        wr_t w;
        if (e_trap) begin
            step(a, d, 1'b1, 1'b0, hw, bt, 1'b0, 1'b0, 32'h0, 1'b1);
        end else begin
            step(a, d, 1'b1, 1'b0, hw, bt, 1'b1, 1'b0, 32'h0, 1'b0);
            step(a, d, 1'b1, 1'b0, hw, bt, 1'b0, 1'b1, 32'h0, 1'b0);
            w.addr = a & 32'hFFFF_FFFC;
            w.data = merged;
            wq.push_back(w);
            exp_cnt = exp_cnt + 16'd1;
        end
    endtask

    initial begin
        Rst_n              = 1'b0;
        EX_MEM_Address     = 32'h0;
        EX_MEM_WriteData   = 32'h0;
        EX_MEM_MemWrite    = 1'b0;
        EX_MEM_MemRead     = 1'b0;
        EX_MEM_HalfControl = 1'b0;
        EX_MEM_ByteControl = 1'b0;

        // Reset state, then release mid-cycle.
        idle();
        idle();
        #2 Rst_n = 1'b1;
        idle();

        // Preload through word stores.
        store_word(32'h10, 32'h1122_3344, 1'b0);
        store_word(32'h20, 32'h80FF_7F01, 1'b0);
        store_word(32'h24, 32'h0000_0000, 1'b0);
        store_word(32'h30, 32'h0000_0000, 1'b0);

        // sb 0xAB -> 0x11 (upper data bits must be ignored).
        store_sub(32'h11, 32'h5555_55AB, 1'b0, 1'b1, 32'h1122_AB44, 1'b0);
        idle();
        load(32'h10, 1'b0, 1'b0, 32'h1122_AB44, 1'b0);

        // Restore, then sh 0xBEEF -> 0x12.
        store_word(32'h10, 32'h1122_3344, 1'b0);
        store_sub(32'h12, 32'h1234_BEEF, 1'b1, 1'b0, 32'hBEEF_3344, 1'b0);
        load(32'h10, 1'b0, 1'b0, 32'hBEEF_3344, 1'b0);

        // Loads from 0x80FF7F01.
        load(32'h23, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b0);
        load(32'h21, 1'b0, 1'b1, 32'h0000_007F, 1'b0);
        load(32'h22, 1'b1, 1'b0, 32'hFFFF_80FF, 1'b0);
        load(32'h20, 1'b0, 1'b0, 32'h80FF_7F01, 1'b0);
        load(32'h20, 1'b1, 1'b0, 32'h0000_7F01, 1'b0);
        load(32'h20, 1'b0, 1'b1, 32'h0000_0001, 1'b0);
        load(32'h22, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        load(32'h22, 1'b1, 1'b1, 32'hFFFF_80FF, 1'b0);

        // No access, and read+write treated as store.
        step(32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        store_word(32'h34, 32'hDEAD_BEEF, 1'b1);

        // Back-to-back byte stores, then load of the merged word.
        store_sub(32'h30, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0001, 1'b0);
        store_sub(32'h31, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0201, 1'b0);
        load(32'h30, 1'b0, 1'b0, 32'h0000_0201, 1'b0);

        // Misaligned accesses: trapped or force-aligned.
        store_sub(32'h13, 32'h0000_1234, 1'b1, 1'b0, 32'h1234_3344, TRAP);
        load(32'h10, 1'b0, 1'b0, TRAP ? 32'hBEEF_3344 : 32'h1234_3344, 1'b0);
        load(32'h22, 1'b0, 1'b0, TRAP ? 32'h0 : 32'h80FF_7F01, TRAP);
        load(32'h21, 1'b1, 1'b0, TRAP ? 32'h0 : 32'h0000_7F01, TRAP);
        idle();

        // Reset pulsed during RMW_WRITE: no write, count cleared.
        step(32'h20, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(posedge Clk);
        #2 Rst_n = 1'b0;
        exp_cnt    = 16'd0;
        misal_pend = 1'b0;
        push_rec(1'b0, 1'b0, 32'h0, 1'b0);
        idle();
        #2 Rst_n = 1'b1;
        idle();
        load(32'h20, 1'b0, 1'b0, 32'h80FF_7F01, 1'b0);

        // Fresh RMW after reset starts from IDLE.
        store_sub(32'h25, 32'h0000_00CD, 1'b0, 1'b1, 32'h0000_CD00, 1'b0);
        load(32'h24, 1'b0, 1'b0, 32'h0000_CD00, 1'b0);
        idle();

        repeat (4) @(posedge Clk);
        done = 1'b1;
    end

endmodule

// File: doc/mem_subword_ctrl.md
# mem_subword_ctrl

Memory-stage access controller between the EX/MEM pipeline register and the dual-port data memory. The data memory's BRAM write enable covers the whole word only, so this block turns byte and halfword stores into a two-cycle read-modify-write and stalls the pipeline for one cycle while it does so. It also aligns and sign-extends byte and halfword loads from the raw word read, and counts read-modify-write operations for performance analysis.

## Interface
- `ADDR_W`, 32: address width.
- `CNT_W`, 16: width of the RMW performance counter.
- `Clk` in 1: pipeline clock. The data memory samples on the falling edge; this block uses the rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `EX_MEM_Address` in ADDR_W: byte address.
- `EX_MEM_WriteData` in 32: store data, right-justified for sub-word stores.
- `EX_MEM_MemWrite`, `EX_MEM_MemRead` in 1 each: access type.
- `EX_MEM_HalfControl`, `EX_MEM_ByteControl` in 1 each: access size. Halfword takes priority if both are set. Word access when neither is set.
- `Mem_ReadData` in 32: raw word from data memory. Valid before the next rising edge.
- `Mem_Address` out ADDR_W: address to data memory. Bits [1:0] are always 0.
- `Mem_WriteData` out 32: full word to write.
- `Mem_MemWrite` out 1: word write enable.
- `Load_Data` out 32: aligned, sign-extended load result.
- `Stall` out 1: holds IF/ID/EX and EX/MEM for the current cycle.
- `Misalign_Err` out 1: one-cycle flag for a misaligned access. Present only with the macro below.
- `Rmw_Count` out CNT_W: saturating count of completed RMW writes.

## Operation
- States: IDLE and RMW_WRITE.
- **IDLE, word store:**
  - Drive `Mem_Address = {addr[ADDR_W-1:2],2'b00}`, `Mem_WriteData = EX_MEM_WriteData`, `Mem_MemWrite = 1`, `Stall = 0`.
  - Stay in IDLE.
- **IDLE, sub-word store:**
  - Drive the word address with `Mem_MemWrite = 0` and `Stall = 1`.
  - On the rising edge, latch the word address, lane (addr[1:0]), size and data.
  - Also latch the merged word: `Mem_ReadData` with the target lane(s) replaced.
  - Go to RMW_WRITE.
- **RMW_WRITE:**
  - Drive the latched address and merged word with `Mem_MemWrite = 1` and `Stall = 0`.
  - `EX_MEM_*` inputs are ignored; they still show the same store.
  - Increment `Rmw_Count`, saturating at all-ones.
  - Return to IDLE unconditionally.
- **Lane mapping:**
  - Byte lane n (n = addr[1:0]) occupies bits [8n+7:8n].
  - Halfword at addr[1]=0 occupies [15:0]; at addr[1]=1 it occupies [31:16].
- **Loads:**
  - Combinational from `Mem_ReadData` and the current address; no stall.
  - Byte loads are sign-extended from bit 7; halfword loads from bit 15; word loads pass through unchanged.
  - `Load_Data` is 0 when `EX_MEM_MemRead = 0`.
- **No access:** `Mem_MemWrite = 0`, `Stall = 0`, and `Mem_Address` follows the aligned input address.
- **MemRead and MemWrite both set:** treated as a store; `Load_Data = 0`.

## Timing
- Word store and all loads: zero added latency, no stall.
- Sub-word store: two cycles, exactly one `Stall` cycle. The write commits at the falling edge of the RMW_WRITE cycle.
- Back-to-back sub-word stores: IDLE, RMW_WRITE, IDLE, RMW_WRITE. A load immediately after an RMW sees the merged data.
- **Reset values:** state IDLE, `Mem_MemWrite` 0, `Stall` 0, `Rmw_Count` 0, `Misalign_Err` 0, latch registers 0.
- **Reset mid-operation:** asserting `Rst_n` low during RMW_WRITE forces `Mem_MemWrite` to 0 immediately, so no partial write occurs.
- **Reset release:** on the first rising edge after release, the block evaluates the inputs from IDLE.

## Configuration
- Macro: `MEM_MISALIGN_TRAP_EN`.
- **Defined:**
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, raises `Misalign_Err` for one cycle. This is a registered pulse in the cycle after the access.
  - The store is suppressed (`Mem_MemWrite = 0`, no RMW, no stall) and `Load_Data = 0`.
- **Undefined:**
  - The `Misalign_Err` port is tied 0.
  - Halfword addr[0] and word addr[1:0] are ignored, so accesses are force-aligned.

## Test plan
- Word 0x10 = 0x11223344; `sb` 0xAB to 0x11 → one `Stall` cycle; memory 0x1122AB44; `Rmw_Count` 1.
- Word 0x10 = 0x11223344; `sh` 0xBEEF to 0x12 → memory 0xBEEF3344.
- Word 0x20 = 0x80FF7F01:
  - `lb` 0x23 → 0xFFFFFF80.
  - `lb` 0x21 → 0x0000007F.
  - `lh` 0x22 → 0xFFFF80FF.
  - `lw` → 0x80FF7F01.
  - No `Stall` for any of these.
- Two consecutive `sb` (0x01→0x30, 0x02→0x31) → `Stall` pattern 1,0,1,0; word 0x00000201; followed by `lw` 0x30 → 0x00000201.
- `Rst_n` pulsed low during RMW_WRITE → `Mem_MemWrite` 0, memory unchanged, state IDLE, `Rmw_Count` 0.
- With `MEM_MISALIGN_TRAP_EN` defined, `sh` to 0x13 → `Misalign_Err` pulse, memory unchanged. Without the macro, the same store writes the [31:16] lane.
